// File: rtl/crypt_pkg.sv
// Shared types for the crypto result capture path: default widths,
// capture FSM states and the packed FIFO entry layout.
package crypt_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_CAPTURE
    } state_t;

    // Entry as stored in the FIFO: op tag in the upper bits, result below.
    typedef struct packed {
        logic [OP_W_DEF-1:0]   op;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;

endpackage

// File: rtl/crypt_fifo_mem.sv
// First-word-fall-through FIFO with a registered head entry.
// count includes the head entry; rd_valid is simply "count != 0" registered.
module crypt_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int EW    = 12
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   push,
    input  logic [EW-1:0]          wdata,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [EW-1:0]          rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   wr_ok,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_nxt;
    logic [CW-1:0] cnt_pop, cnt_nxt;
    logic          pop, full;

    assign pop      = rd_valid & rd_ready;
    assign full     = (count == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full push can still land.
    assign wr_ok    = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign cnt_pop  = pop ? count - CW'(1) : count;
    assign cnt_nxt  = wr_ok ? cnt_pop + CW'(1) : cnt_pop;
    assign rptr_nxt = pop ? rptr + AW'(1) : rptr;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge CLK) begin
        if (wr_ok) mem[wptr] <= wdata;
    end

    // Pointers, occupancy and the registered head entry.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + AW'(1);
            rptr     <= rptr_nxt;
            count    <= cnt_nxt;
            rd_valid <= (cnt_nxt != '0);
            // When the FIFO drains to empty, the incoming word bypasses
            // storage straight into the head; with nothing arriving the
            // head keeps its last value.
            if (cnt_pop == '0) begin
                if (wr_ok) rd_data <= wdata;
            end else begin
                rd_data <= mem[rptr_nxt];
            end
        end
    end

endmodule

// File: rtl/crypt_result_fifo.sv
// Captures the crypto core result CORE_LAT cycles after each op_load,
// tags it with the op code and queues it for the readout side.
// Optional: define CRYPT_RESULT_CHECKSUM_EN to enable the chk accumulator.
module crypt_result_fifo
    import crypt_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int OP_W     = OP_W_DEF,
    parameter int CORE_LAT = 2
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   op_load,
    input  logic [OP_W-1:0]        op_code,
    input  logic [DATA_W-1:0]      core_out,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [DATA_W-1:0]      rd_data,
    output logic [OP_W-1:0]        rd_op,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   overflow,
    output logic [DATA_W-1:0]      chk
);

    localparam int LW = $clog2(CORE_LAT + 1);
    localparam int EW = OP_W + DATA_W;

    state_t          state, state_nxt;
    logic [LW-1:0]   lat_cnt, lat_nxt;
    logic [OP_W-1:0] op_lat, op_nxt;
    logic            push, wr_ok, drop;
    logic [EW-1:0]   head;

    // Capture state, latency counter and latched op.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            op_lat  <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            op_lat  <= op_nxt;
        end
    end

    // Next state: WAIT counts down so that CAPTURE lands exactly CORE_LAT
    // cycles after op_load, the cycle core_out is valid. Any op_load
    // (re)starts tracking, abandoning a pending op but never a CAPTURE push.
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat_cnt;
        op_nxt    = op_lat;
        push      = 1'b0;
        case (state)
            ST_IDLE: ;
            ST_WAIT: begin
                lat_nxt = lat_cnt - LW'(1);
                if (lat_nxt == '0) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                push      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (op_load) begin
            op_nxt    = op_code;
            lat_nxt   = LW'(CORE_LAT - 1);
            state_nxt = (CORE_LAT == 1) ? ST_CAPTURE : ST_WAIT;
        end
    end

    assign busy = (state == ST_WAIT);

    crypt_fifo_mem #(.DEPTH(DEPTH), .EW(EW)) u_mem (
        .CLK      (CLK),
        .Reset    (Reset),
        .push     (push),
        .wdata    ({op_lat, core_out}),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (head),
        .count    (count),
        .wr_ok    (wr_ok),
        .drop     (drop)
    );

    assign rd_op   = head[EW-1:DATA_W];
    assign rd_data = head[DATA_W-1:0];

    // Sticky flag for any capture lost to a full FIFO.
    always_ff @(posedge CLK) begin
        if (Reset)     overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifdef CRYPT_RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] chk_q;

    // Rotate-left then XOR in each result actually stored.
    always_ff @(posedge CLK) begin
        if (Reset)      chk_q <= '0;
        else if (wr_ok) chk_q <= {chk_q[DATA_W-2:0], chk_q[DATA_W-1]} ^ core_out;
    end

    assign chk = chk_q;
`else
    wire unused_wr_ok = wr_ok;

    assign chk = '0;
`endif

endmodule

// File: tb/tb_crypt_result_fifo.sv
// Scoreboard bench for crypt_result_fifo (DEPTH=4, CORE_LAT=2).
module tb_crypt_result_fifo;
    import crypt_pkg::*;

    localparam int DEPTH    = 4;
    localparam int CORE_LAT = 2;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       op_load = 1'b0;
    logic [3:0] op_code = '0;
    logic [7:0] core_out = '0;
    logic       rd_ready = 1'b0;
    logic       rd_valid, busy, overflow;
    logic [7:0] rd_data, chk;
    logic [3:0] rd_op;
    logic [2:0] count;

    int errors = 0;
    int checks = 0;
    entry_t sb[$];
    logic       exp_ovf = 1'b0;
    logic [7:0] exp_chk = '0;

    crypt_result_fifo #(.DEPTH(DEPTH), .DATA_W(8), .OP_W(4), .CORE_LAT(CORE_LAT)) dut (
        .CLK(CLK), .Reset(Reset), .op_load(op_load), .op_code(op_code),
        .core_out(core_out), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_op(rd_op), .count(count), .busy(busy),
        .overflow(overflow), .chk(chk)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [3:0] op, input logic [7:0] data);
        entry_t e;
        e.op   = op;
        e.data = data;
        sb.push_back(e);
`ifdef CRYPT_RESULT_CHECKSUM_EN
        exp_chk = {exp_chk[6:0], exp_chk[7]} ^ data;
`endif
    endtask

    task automatic check_head(input string tag);
        entry_t e;
        e = sb.pop_front();
        expect_eq({tag, "_valid"}, rd_valid, 1'b1);
        expect_eq({tag, "_data"}, rd_data, e.data);
        expect_eq({tag, "_op"}, rd_op, e.op);
    endtask

    task automatic pop_one(input string tag);
        check_head(tag);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        expect_eq({tag, "_cnt"}, count, sb.size());
    endtask

    task automatic drain(input string tag);
        while (sb.size() > 0) pop_one(tag);
        expect_eq({tag, "_empty"}, rd_valid, 1'b0);
    endtask

    // Issue one op; core_out holds data through the capture cycle.
    // With pop set, the head is consumed on the same edge as the push.
    task automatic do_op(input logic [3:0] op, input logic [7:0] data, input bit pop);
        op_load  = 1'b1;
        op_code  = op;
        core_out = data;
        tick();
        op_load = 1'b0;
        repeat (CORE_LAT - 1) tick();
        if (pop) begin
            check_head("pp");
            rd_ready = 1'b1;
        end
        if (pop || sb.size() < DEPTH) sb_push(op, data);
        else exp_ovf = 1'b1;
        tick();
        rd_ready = 1'b0;
        expect_eq("op_cnt", count, sb.size());
        expect_eq("op_ovf", overflow, exp_ovf);
        expect_eq("op_chk", chk, exp_chk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        exp_chk = '0;
    endtask

    initial begin
        tick();
        do_reset();
        expect_eq("rst_valid", rd_valid, 1'b0);
        expect_eq("rst_cnt", count, 0);
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_ovf", overflow, 1'b0);
        expect_eq("rst_chk", chk, 0);
        expect_eq("rst_data", rd_data, 0);
        expect_eq("rst_op", rd_op, 0);

        // Basic latency: rd_valid appears on the third edge after op_load.
        op_load = 1'b1; op_code = 4'h3; core_out = 8'hA5;
        tick();
        op_load = 1'b0;
        expect_eq("b_busy", busy, 1'b1);
        tick();
        expect_eq("b_early", rd_valid, 1'b0);
        tick();
        sb_push(4'h3, 8'hA5);
        expect_eq("b_cnt", count, 1);
        expect_eq("b_chk", chk, exp_chk);
        tick();
        expect_eq("b_hold", rd_data, 8'hA5);
        pop_one("b");
        expect_eq("b_valid0", rd_valid, 1'b0);
        expect_eq("b_keep", rd_data, 8'hA5);

        // Restart: second op_load while waiting replaces the first.
        op_load = 1'b1; op_code = 4'h1; core_out = 8'h11;
        tick();
        op_code = 4'h2; core_out = 8'h22;
        tick();
        op_load = 1'b0;
        tick();
        tick();
        sb_push(4'h2, 8'h22);
        repeat (3) tick();
        expect_eq("rs_cnt", count, 1);
        drain("rs");

        // Full: fifth op is dropped, order preserved.
        do_reset();
        for (int i = 1; i <= 5; i++) do_op(4'(i), 8'(i), 1'b0);
        expect_eq("f_ovf", overflow, 1'b1);
        drain("f");
        expect_eq("f_ovf_sticky", overflow, 1'b1);

        // Push with simultaneous pop at full: no overflow, count stays 4.
        do_reset();
        for (int i = 1; i <= 4; i++) do_op(4'(i), 8'(8'h10 + i), 1'b0);
        do_op(4'h5, 8'h15, 1'b1);
        expect_eq("fp_cnt", count, 4);
        expect_eq("fp_ovf", overflow, 1'b0);
        drain("fp");

        // Back-to-back: op_load in the CAPTURE cycle.
        op_load = 1'b1; op_code = 4'h7; core_out = 8'h77;
        tick();
        op_load = 1'b0;
        tick();
        op_load = 1'b1; op_code = 4'h8;
        sb_push(4'h7, 8'h77);
        tick();
        op_load = 1'b0; core_out = 8'h88;
        expect_eq("bb_busy", busy, 1'b1);
        expect_eq("bb_cnt1", count, 1);
        tick();
        tick();
        sb_push(4'h8, 8'h88);
        expect_eq("bb_cnt2", count, 2);
        expect_eq("bb_chk", chk, exp_chk);
        drain("bb");

        // Reset while waiting with two entries held.
        do_op(4'h9, 8'h99, 1'b0);
        do_op(4'hA, 8'hAA, 1'b0);
        op_load = 1'b1; op_code = 4'hB; core_out = 8'hBB;
        tick();
        op_load = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sb.delete();
        exp_ovf = 1'b0;
        exp_chk = '0;
        expect_eq("mr_cnt", count, 0);
        expect_eq("mr_busy", busy, 1'b0);
        expect_eq("mr_valid", rd_valid, 1'b0);
        repeat (4) tick();
        expect_eq("mr_nocap", count, 0);
        expect_eq("mr_nocapv", rd_valid, 1'b0);
        expect_eq("mr_chk", chk, 0);

        // Checksum pattern: 01 then 80.
        do_op(4'h1, 8'h01, 1'b0);
        do_op(4'h2, 8'h80, 1'b0);
`ifdef CRYPT_RESULT_CHECKSUM_EN
        expect_eq("cs_val", chk, 8'h82);
`else
        expect_eq("cs_val", chk, 8'h00);
`endif
        drain("cs");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crypt_result_fifo.md
Name: crypt_result_fifo

Overview:
- Downstream stage of the arithmetic crypto core.
- Tracks each operation issued to the core and waits the core's fixed latency.
- Captures the core's 8-bit OUTPUT, tagged with its 4-bit op code, into a small FIFO.
- Presents results to the pin/readout logic through a valid/ready interface, so results are not lost when the readout side stalls.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- DATA_W, 8, width of core result.
- OP_W, 4, width of op tag.
- CORE_LAT, 2, cycles from op_load to a valid core_out (1..15).

Ports:
- CLK  input  1  clock; all logic rising-edge.
- Reset  input  1  synchronous, active-high reset.
- op_load  input  1  one-cycle pulse: new operands/op applied to the core this cycle.
- op_code  input  OP_W  op applied with op_load; sampled when op_load=1.
- core_out  input  DATA_W  core OUTPUT bus.
- rd_valid  output  1  head entry available.
- rd_ready  input  1  consumer accepts head entry.
- rd_data  output  DATA_W  head result.
- rd_op  output  OP_W  op tag of head result.
- count  output  $clog2(DEPTH)+1  entries held.
- busy  output  1  capture pending (WAIT state).
- overflow  output  1  sticky: a capture was dropped.
- chk  output  DATA_W  running checksum (see Optional Feature).

Behaviour:
- Reset (synchronous, CLK edge with Reset=1):
  - FSM→IDLE, pointers and count=0, rd_valid=0, rd_data=0, rd_op=0, busy=0, overflow=0, chk=0.
  - Any pending capture is abandoned.
- FSM states:
  - IDLE: on op_load, latch op_code, load lat_cnt=CORE_LAT-1, go to WAIT.
  - WAIT: busy=1.
    - lat_cnt decrements each cycle.
    - When lat_cnt==0 and no op_load, go to CAPTURE.
    - op_load during WAIT (including the lat_cnt==0 cycle): restart, re-latch op, reload counter; the earlier op is never captured.
  - CAPTURE: one cycle; push {op_latched, core_out} and return to IDLE.
    - op_load in the CAPTURE cycle: still push, then go to WAIT for the new op (not IDLE).
- Latency: entry becomes visible (rd_valid=1) on the cycle after CAPTURE.
  - op_load at cycle t → CAPTURE at t+CORE_LAT → rd_valid at t+CORE_LAT+1 when the FIFO was empty.
- FIFO:
  - First-word-fall-through, registered outputs.
  - Pop occurs when rd_valid & rd_ready.
  - rd_data/rd_op hold the head entry steady while rd_valid=1 and rd_ready=0.
  - Empty: rd_valid=0; rd_data/rd_op hold their last value; rd_ready is ignored.
  - Full push with no pop: entry dropped, overflow set (sticky until Reset), count unchanged.
  - Full push with simultaneous pop: both happen, no overflow, count unchanged.
  - Pointers wrap modulo DEPTH.
  - count is always equal to pushes minus pops and never exceeds DEPTH.
- Arithmetic: unsigned; lat_cnt width $clog2(CORE_LAT+1); no saturation other than the FIFO-full drop.

Optional Feature:
- Macro: CRYPT_RESULT_CHECKSUM_EN.
- Defined:
  - chk = XOR-rotate accumulator: chk ← {chk[DATA_W-2:0], chk[DATA_W-1]} ^ core_out on every successful push.
  - Dropped pushes do not update chk.
  - chk is cleared by Reset.
- Not defined: chk is tied to 0 and no accumulator flops exist. The port is always present.

Decomposition:
- Package crypt_pkg:
  - DATA_W/OP_W defaults.
  - FSM state enum {ST_IDLE, ST_WAIT, ST_CAPTURE}.
  - fifo entry struct {op, data}.
- Sub-module crypt_fifo_mem: storage array, read/write pointers, count, full/empty, FWFT head register.
- Top: FSM, latency counter, overflow and checksum logic.

Test Plan:
- Basic: Reset, then op_load with op_code=4'h3 and core_out=8'hA5 at the capture cycle → rd_valid rises 3 cycles after op_load (CORE_LAT=2), rd_data=A5, rd_op=3, count=1. rd_ready=1 → count=0, rd_valid=0.
- Restart: op_load(op=1), then op_load(op=2) one cycle later → exactly one entry, rd_op=2.
- Full/overflow: 5 ops (values 01..05) with rd_ready=0 → count=4, overflow=1, entries drain in order 01,02,03,04. A push with simultaneous pop at full → overflow unchanged, count stays 4.
- Back-to-back: op_load in the CAPTURE cycle → both results stored in order, busy stays high through the second wait.
- Mid-operation Reset: Reset asserted while in WAIT with 2 entries held → next cycle count=0, busy=0, rd_valid=0, and no capture occurs afterwards.
- Checksum (CRYPT_RESULT_CHECKSUM_EN): push 8'h01 then 8'h80 → chk=8'h82. Without the macro, chk stays 0.
